// File: rtl/proc_pkg.sv
// Shared processor constants: sequencer state encoding, default phase prescale,
// datapath opcodes and a small counter-width helper.
package proc_pkg;

  localparam logic [2:0] SEQ_IDLE   = 3'd0;
  localparam logic [2:0] SEQ_FETCH  = 3'd1;
  localparam logic [2:0] SEQ_DECODE = 3'd2;
  localparam logic [2:0] SEQ_EXEC   = 3'd3;
  localparam logic [2:0] SEQ_WB     = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4
  } seq_state_e;

  localparam int unsigned DEFAULT_PRESCALE = 50_000_000;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase dwell counter: counts 0..PRESCALE-1, ticks on the last count and wraps.
// clear holds the count at zero.
module phase_timer
  import proc_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(PRESCALE);
  localparam logic [CntW-1:0] Last = CntW'(PRESCALE - 1);

  logic [CntW-1:0] count_q;

  assign tick = (count_q == Last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Run/halt/single-step instruction-phase sequencer issuing fetch/decode/exec/wb strobes.
// Optional breakpoint stop on run entry is enabled by defining EXEC_SEQ_BREAKPOINT_EN.
module exec_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              halt_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] bp_addr_i,
  input  logic              bp_valid_i,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              exec_en,
  output logic              wb_en,
  output logic              busy,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic              bp_hit
);

  seq_state_e       state_q;
  logic             single_q;
  logic             step_q;
  logic             busy_q;
  logic             bp_hit_q;
  logic [CNT_W-1:0] cnt_q;

  logic tick;
  logic step_rise;
  logic run_go;
  logic bp_match;

  phase_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == StIdle),
    .tick (tick)
  );

  assign step_rise = step_i & ~step_q;
  assign run_go    = run_i & ~halt_i;

`ifdef EXEC_SEQ_BREAKPOINT_EN
  assign bp_match = bp_valid_i && (pc_i == bp_addr_i);
`else
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign unused_bp = ^{bp_valid_i, pc_i, bp_addr_i};
`endif

  // Strobes mark the final dwell cycle of each phase, so they can never overlap.
  assign fetch_en  = tick && (state_q == StFetch);
  assign decode_en = tick && (state_q == StDecode);
  assign exec_en   = tick && (state_q == StExec);
  assign wb_en     = tick && (state_q == StWb);

  assign busy      = busy_q;
  assign state_o   = state_q;
  assign instr_cnt = cnt_q;
  assign bp_hit    = bp_hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      single_q <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      bp_hit_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      step_q <= step_i;
      if (wb_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          // Run wins over a simultaneous step; only run entry honours the breakpoint.
          if (run_go) begin
            if (bp_match) begin
              bp_hit_q <= 1'b1;
            end else begin
              state_q  <= StFetch;
              busy_q   <= 1'b1;
              single_q <= 1'b0;
              bp_hit_q <= 1'b0;
            end
          end else if (step_rise) begin
            state_q  <= StFetch;
            busy_q   <= 1'b1;
            single_q <= 1'b1;
            bp_hit_q <= 1'b0;
          end
        end
        StFetch:  if (tick) state_q <= StDecode;
        StDecode: if (tick) state_q <= StExec;
        StExec:   if (tick) state_q <= StWb;
        StWb: begin
          if (tick) begin
            if (run_go && !single_q && !bp_match) begin
              state_q <= StFetch;
            end else begin
              state_q  <= StIdle;
              busy_q   <= 1'b0;
              single_q <= 1'b0;
              if (run_go && !single_q) begin
                bp_hit_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          single_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: cycle model of instruction progress plus directed literal checks.
module tb_exec_sequencer;

  localparam int unsigned P  = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 4;
`ifdef EXEC_SEQ_BREAKPOINT_EN
  localparam bit BpOn = 1'b1;
`else
  localparam bit BpOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run_i = 1'b0;
  logic          step_i = 1'b0;
  logic          halt_i = 1'b0;
  logic          bp_valid_i = 1'b0;
  logic [AW-1:0] pc_i = '0;
  logic [AW-1:0] bp_addr_i = '0;
  logic          fetch_en, decode_en, exec_en, wb_en, busy, bp_hit;
  logic [2:0]    state_o;
  logic [CW-1:0] instr_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  exec_sequencer #(
    .PRESCALE(P),
    .ADDR_W  (AW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (run_i),
    .step_i    (step_i),
    .halt_i    (halt_i),
    .pc_i      (pc_i),
    .bp_addr_i (bp_addr_i),
    .bp_valid_i(bp_valid_i),
    .fetch_en  (fetch_en),
    .decode_en (decode_en),
    .exec_en   (exec_en),
    .wb_en     (wb_en),
    .busy      (busy),
    .state_o   (state_o),
    .instr_cnt (instr_cnt),
    .bp_hit    (bp_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: an instruction is 4*P cycles; m_k is the cycle index within it.
  bit          m_active, m_single, m_bphit, m_step_prev, m_rise, m_bp;
  int unsigned m_k, m_cnt;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 0; m_single = 0; m_bphit = 0; m_step_prev = 0; m_k = 0; m_cnt = 0;
    end else begin
      m_rise      = step_i && !m_step_prev;
      m_step_prev = step_i;
      m_bp        = BpOn && bp_valid_i && (pc_i == bp_addr_i);
      if (m_active) begin
        if (m_k == 4 * P - 1) begin
          m_cnt = (m_cnt + 1) % (1 << CW);
          if (run_i && !halt_i && !m_single) begin
            if (m_bp) begin m_active = 0; m_bphit = 1; end
            else m_k = 0;
          end else begin
            m_active = 0; m_single = 0;
          end
        end else begin
          m_k++;
        end
      end else if (run_i && !halt_i) begin
        if (m_bp) m_bphit = 1;
        else begin m_active = 1; m_k = 0; m_single = 0; m_bphit = 0; end
      end else if (m_rise) begin
        m_active = 1; m_k = 0; m_single = 1; m_bphit = 0;
      end
    end
  end

  function automatic logic [3:0] exp_strobes();
    if (!m_active || (m_k % P) != P - 1) return 4'b0000;
    return 4'b1000 >> (m_k / P);
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("strobes", 32'({fetch_en, decode_en, exec_en, wb_en}), 32'(exp_strobes()));
      chk("onehot", 32'($onehot0({fetch_en, decode_en, exec_en, wb_en})), 32'd1);
      chk("state_o", 32'(state_o), m_active ? (1 + m_k / P) : 32'd0);
      chk("busy", 32'(busy), 32'(m_active));
      chk("instr_cnt", 32'(instr_cnt), m_cnt);
      chk("bp_hit", 32'(bp_hit), 32'(m_bphit));
    end
  end

  task automatic step_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (state_o == s) ok = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  int unsigned fq[$], dq[$], eq[$], wq[$];
  int unsigned nbusy, nf, ne, nw;
  bit ok, prev_wb;

  initial begin
    step_cyc(3);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    rst_n = 1'b1;
    step_cyc(2);

    // Free run: three instructions, cycle 1 is the first cycle run_i is high.
    run_i = 1'b1;
    nbusy = 0;
    for (int unsigned r = 1; r <= 52; r++) begin
      if (r > 1) @(negedge clk);
      if (fetch_en) fq.push_back(r);
      if (decode_en) dq.push_back(r);
      if (exec_en) eq.push_back(r);
      if (wb_en) wq.push_back(r);
      if (busy) nbusy++;
      if (r == 49) run_i = 1'b0;
    end
    chk("t2_nfetch", 32'(fq.size()), 32'd3);
    chk("t2_fetch0", fq[0], 32'd5);
    chk("t2_decode0", dq[0], 32'd9);
    chk("t2_exec0", eq[0], 32'd13);
    chk("t2_wb0", wq[0], 32'd17);
    chk("t2_fetch1", fq[1], 32'd21);
    chk("t2_wb1", wq[1], 32'd33);
    chk("t2_wb2", wq[2], 32'd49);
    chk("t2_busy_cycles", nbusy, 32'd48);
    chk("t2_cnt", 32'(instr_cnt), 32'd3);

    // Asynchronous reset in the middle of EXEC.
    run_i = 1'b1;
    wait_state(3'd3, 40, ok);
    chk("t1_reach_exec", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_strobes", 32'({fetch_en, decode_en, exec_en, wb_en}), 32'd0);
    chk("t1_state", 32'(state_o), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_cnt", 32'(instr_cnt), 32'd0);
    chk("t1_bp", 32'(bp_hit), 32'd0);
    @(negedge clk);
    run_i = 1'b0;
    rst_n = 1'b1;
    step_cyc(8);
    chk("t1_stay_idle", 32'(state_o), 32'd0);

    // Single step: one pulse, then step held for 40 cycles.
    step_i = 1'b1;
    @(negedge clk);
    step_i = 1'b0;
    nw = 0; prev_wb = 0;
    for (int unsigned r = 0; r < 24; r++) begin
      @(negedge clk);
      if (prev_wb) chk("t3_idle_after_wb", 32'(busy), 32'd0);
      prev_wb = wb_en;
      if (wb_en) nw++;
    end
    chk("t3_one_step", nw, 32'd1);
    step_i = 1'b1;
    for (int unsigned r = 0; r < 40; r++) begin
      @(negedge clk);
      if (prev_wb) chk("t3_idle_after_wb", 32'(busy), 32'd0);
      prev_wb = wb_en;
      if (wb_en) nw++;
    end
    step_i = 1'b0;
    step_cyc(2);
    chk("t3_total", nw, 32'd2);
    chk("t3_cnt", 32'(instr_cnt), 32'd2);
    chk("t3_busy", 32'(busy), 32'd0);

    // Halt during DECODE of the second instruction.
    run_i = 1'b1;
    wait_state(3'd4, 40, ok);
    chk("t4_reach_wb", 32'(ok), 32'd1);
    wait_state(3'd2, 40, ok);
    chk("t4_reach_decode", 32'(ok), 32'd1);
    halt_i = 1'b1;
    nf = 0; ne = 0; nw = 0;
    for (int unsigned r = 0; r < 30; r++) begin
      @(negedge clk);
      if (fetch_en) nf++;
      if (exec_en) ne++;
      if (wb_en) nw++;
    end
    chk("t4_exec", ne, 32'd1);
    chk("t4_wb", nw, 32'd1);
    chk("t4_nofetch", nf, 32'd0);
    chk("t4_state", 32'(state_o), 32'd0);
    chk("t4_cnt", 32'(instr_cnt), 32'd4);
    halt_i = 1'b0;
    run_i  = 1'b0;
    step_cyc(2);

    // Breakpoint at address 3.
    bp_addr_i = 4'd3; pc_i = 4'd3; bp_valid_i = 1'b1; run_i = 1'b1;
    nf = 0;
    for (int unsigned r = 0; r < 12; r++) begin
      @(negedge clk);
      if (fetch_en) nf++;
    end
`ifdef EXEC_SEQ_BREAKPOINT_EN
    chk("t5_nofetch", nf, 32'd0);
    chk("t5_bp_hit", 32'(bp_hit), 32'd1);
    chk("t5_state", 32'(state_o), 32'd0);
`else
    chk("t5_fetch_seen", 32'(nf != 0), 32'd1);
    chk("t5_bp_hit", 32'(bp_hit), 32'd0);
`endif
    run_i = 1'b0;
    step_cyc(20);
    step_i = 1'b1;
    @(negedge clk);
    step_i = 1'b0;
    nw = 0;
    for (int unsigned r = 0; r < 24; r++) begin
      @(negedge clk);
      if (wb_en) nw++;
    end
    chk("t5_step_wb", nw, 32'd1);
    chk("t5_bp_cleared", 32'(bp_hit), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
`ifdef EXEC_SEQ_BREAKPOINT_EN
    chk("t5_cnt", 32'(instr_cnt), 32'd5);
`else
    chk("t5_cnt", 32'(instr_cnt), 32'd6);
`endif
    bp_valid_i = 1'b0;

    // Wrap: 16 retirements on a 4-bit counter; run and step start together.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_i = 1'b1;
    step_i = 1'b1;
    nw = 0;
    for (int unsigned r = 1; r <= 262; r++) begin
      if (r > 1) @(negedge clk);
      if (r == 2) step_i = 1'b0;
      if (wb_en) nw++;
      if (r == 250) chk("t6_cnt_max", 32'(instr_cnt), 32'd15);
      if (r == 257) run_i = 1'b0;
    end
    chk("t6_retired", nw, 32'd16);
    chk("t6_cnt_wrap", 32'(instr_cnt), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
